// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// The mask helper works on a fixed 32-bit width, so MAX_LEN must not exceed MASK_MAX.
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        HUNT  = 2'd2
    } state_t;

    localparam int MASK_MAX = 32;

    // Width needed to hold any length from 0 up to max_len inclusive.
    function automatic int len_w_of(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic [MASK_MAX-1:0] len_mask(input int unsigned len);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// registered match pulse and saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_w_of(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               din_valid,
    input  logic               din,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    input  logic               cnt_clr,
    output logic               armed,
    output logic [1:0]         dbg_state_o
);

    // Handshake: din is consumed on any edge where din_valid=1, the block is
    // configured and cfg_we=0; there is no back-pressure, the source never stalls.

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;

    logic               cfg_legal;
    logic               accept;
    logic               hit;
    logic [MAX_LEN-1:0] len_mask_w;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;

    assign len_mask_w = MAX_LEN'(len_mask(32'(len_q)));
    assign hist_next  = MAX_LEN'({hist_q, din});
    assign fill_next  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

    always_comb begin
        cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        // A config write always claims the cycle, so the data bit is dropped.
        accept    = din_valid && !cfg_we && (state_q != UNCFG);
        hit       = accept
                    && ((hist_next & len_mask_w) == (pat_q & len_mask_w))
                    && (fill_next >= len_q);
    end

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pat_d     = pat_q;
        len_d     = len_q;
        fill_d    = fill_q;
        ovl_d     = ovl_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        if (cfg_we) begin
            if (cfg_legal) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (accept) begin
            hist_d  = hist_next;
            fill_d  = fill_next;
            state_d = (fill_next >= len_q) ? HUNT : FILL;
            if (hit) begin
                match_d = 1'b1;
                // Non-overlapping: the matched bits may not seed the next match.
                if (!ovl_q) begin
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNCFG;
            hist_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            fill_q    <= '0;
            ovl_q     <= 1'b0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (match_d),
        .clr_i (cnt_clr),
        .cnt_o (match_cnt)
    );

    assign match       = match_q;
    assign cfg_err     = cfg_err_q;
    assign armed       = (state_q != UNCFG);
    assign dbg_state_o = state_q;

endmodule
